// File: rtl/time_counter_pkg.sv
// Shared definitions for the TimeCounter button path: press codes and classifier FSM states.
package time_counter_pkg;

  localparam logic [1:0] BTN_NONE  = 2'd0;
  localparam logic [1:0] BTN_SHORT = 2'd1;
  localparam logic [1:0] BTN_LONG  = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StLongWait
  } press_state_e;

endpackage

// File: rtl/button_press_classifier_if.sv
// Button-side signal bundle: raw button in, debounced level and press code out.
interface button_press_classifier_if;
  import time_counter_pkg::*;

  logic       btn_raw;
  logic [1:0] buttonState;
  logic       btn_level;

  modport master (
    output btn_raw,
    input  buttonState,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    output buttonState,
    output btn_level
  );

endinterface

// File: rtl/button_debouncer.sv
// Polarity correction, two-flop synchroniser and stable-count debouncer for a push-button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level
);
  import time_counter_pkg::*;

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            btn_pol;
  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  assign btn_pol = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_pol;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies each debounced button press as short or long and emits a one-cycle code.
module button_press_classifier #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned LONG_CYCLES     = 10,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  button_press_classifier_if.slave   btn_if
);
  import time_counter_pkg::*;

  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic             btn_level;
  press_state_e     state_q;
  logic [HoldW-1:0] hold_q;
  logic [1:0]       code_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_if.btn_raw),
    .btn_level (btn_level)
  );

  // hold_q counts cycles with btn_level high; it stops at LONG_CYCLES in StLongWait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      code_q  <= BTN_NONE;
    end else begin
      code_q <= BTN_NONE;
      case (state_q)
        StIdle: begin
          if (btn_level) begin
            state_q <= StHeld;
            hold_q  <= HoldW'(1);
          end
        end
        StHeld: begin
          if (btn_level) begin
            hold_q <= hold_q + HoldW'(1);
            if (hold_q == HoldLast) begin
              code_q  <= BTN_LONG;
              state_q <= StLongWait;
            end
          end else begin
            code_q  <= BTN_SHORT;
            state_q <= StIdle;
          end
        end
        StLongWait: begin
          if (!btn_level) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign btn_if.buttonState = code_q;
  assign btn_if.btn_level   = btn_level;

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier: directed presses queue expected codes.
module tb_button_press_classifier;
  import time_counter_pkg::*;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  code;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  button_press_classifier_if bus ();

  button_press_classifier #(
    .DEBOUNCE_CYCLES (2),
    .LONG_CYCLES     (10),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_if (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned edge_n   = 0;
  int          checks   = 0;
  int          failures = 0;
  int          n_pushed = 0;
  int          n_seen   = 0;
  bit          mon_en   = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: every non-zero code must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en && bus.buttonState !== BTN_NONE) begin
      checks++;
      n_seen++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_code cyc=%0d got=%0d want=none", edge_n, bus.buttonState);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.buttonState !== mon_e.code || edge_n != mon_e.cyc) begin
          failures++;
          $display("FAIL code got=%0d@cyc%0d want=%0d@cyc%0d",
                   bus.buttonState, edge_n, mon_e.code, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, edge_n);
    end
  endtask

  task automatic push(input int unsigned cyc, input logic [1:0] code);
    exp_t e;
    e.cyc  = cyc;
    e.code = code;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Called at a negedge; raw is high for edges 0..hi-1 of the press.
  task automatic press(input int hi, input int lo, input logic [1:0] code, input int rel);
    bus.btn_raw = 1'b1;
    push(edge_n + rel, code);
    repeat (hi) @(negedge clk);
    bus.btn_raw = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int unsigned t0;
    reset       = 1'b1;
    bus.btn_raw = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // Reset held with the button pressed: nothing may come out.
    repeat (5) begin
      @(negedge clk);
      chk("rst_level", 32'(bus.btn_level), 32'd0);
      chk("rst_code", 32'(bus.buttonState), 32'(BTN_NONE));
    end
    reset       = 1'b0;
    bus.btn_raw = 1'b0;
    repeat (6) @(negedge clk);

    // Short press: level high cycles 4..8, short code at cycle 10.
    bus.btn_raw = 1'b1;
    t0 = edge_n;
    push(t0 + 10, BTN_SHORT);
    for (int c = 0; c <= 12; c++) begin
      if (c == 5) bus.btn_raw = 1'b0;
      chk("level_short", 32'(bus.btn_level), 32'((c >= 4 && c <= 8) ? 1 : 0));
      @(negedge clk);
    end
    repeat (5) @(negedge clk);

    // Long press, nothing on release.
    press(25, 10, BTN_LONG, 14);

    // LONG_CYCLES-1 vs LONG_CYCLES boundary.
    press(9, 10, BTN_SHORT, 14);
    press(10, 10, BTN_LONG, 14);

    // Single-cycle bounce never reaches the debounced level.
    for (int c = 0; c < 12; c++) begin
      bus.btn_raw = (c < 4) ? ~c[0] : 1'b0;
      @(negedge clk);
      chk("bounce_level", 32'(bus.btn_level), 32'd0);
    end

    // Back-to-back short presses.
    for (int i = 0; i < 59; i++) press(5, 5, BTN_SHORT, 10);

    // Reset mid-hold: post-reset level rises at cycle 15, long code at cycle 25.
    bus.btn_raw = 1'b1;
    t0 = edge_n;
    push(t0 + 25, BTN_LONG);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_level", 32'(bus.btn_level), 32'd0);
    end
    reset = 1'b0;
    repeat (19) @(negedge clk);
    bus.btn_raw = 1'b0;
    repeat (12) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("code_count", 32'(n_seen), 32'(n_pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
